// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: two requesters share one register-file write port,
// with a starvation guard for the long-latency path and a RAW busy scoreboard.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  input  logic [4:0]  r0_rd,
  input  logic [31:0] r0_data,
  output logic        r0_ready,
  input  logic        r1_valid,
  input  logic [4:0]  r1_rd,
  input  logic [31:0] r1_data,
  output logic        r1_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        wb_we,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic [31:0] busy
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [31:0]      busy_q, busy_nxt;
  logic             force_r1;
  logic             acc;
  logic [4:0]       acc_rd;
  logic [31:0]      acc_data;

  // Handshake: a transfer happens when rN_valid && rN_ready. Readies depend only
  // on the valids and the starvation counter, at most one is high, and a ready
  // is never high without its valid. Denied requesters hold their request.
  always_comb begin
    force_r1 = r1_valid && (cnt_q == LIMIT);
    r1_ready = force_r1 || (r1_valid && !r0_valid);
    r0_ready = r0_valid && !r1_ready;
    acc      = r0_ready || r1_ready;
    acc_rd   = r1_ready ? r1_rd   : r0_rd;
    acc_data = r1_ready ? r1_data : r0_data;
  end

  always_comb begin
    cnt_nxt = '0;
    if (r1_valid && !r1_ready)
      cnt_nxt = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
  end

  // Clear on accept, then set on issue, so a same-cycle reissue stays busy.
  always_comb begin
    busy_nxt = busy_q;
    if (acc && acc_rd != 5'd0)
      busy_nxt[acc_rd] = 1'b0;
    if (iss_valid && iss_rd != 5'd0)
      busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= '0;
    end else begin
      cnt_q  <= cnt_nxt;
      busy_q <= busy_nxt;
    end
  end

  // Writes to x0 complete the handshake but never raise the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we   <= 1'b0;
      wb_reg  <= '0;
      wb_data <= '0;
    end else if (acc) begin
      wb_we   <= (acc_rd != 5'd0);
      wb_reg  <= acc_rd;
      wb_data <= acc_data;
    end else begin
      wb_we   <= 1'b0;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_wb_port_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r1_valid, iss_valid;
  logic [4:0]  r0_rd, r1_rd, iss_rd;
  logic [31:0] r0_data, r1_data;
  logic        r0_ready, r1_ready;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [31:0] busy;

  wb_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_rd(r0_rd), .r0_data(r0_data), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_rd(r1_rd), .r1_data(r1_data), .r1_ready(r1_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  logic [36:0] exp_q[$];
  bit   [31:0] m_busy;
  int          m_wait;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  bit          m_known;

  int n_checks = 0;
  int n_fail   = 0;
  bit g0, g1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: check outputs against the model, advance the model, step.
  task automatic step(output bit eg0, output bit eg1);
    logic [36:0] e;
    logic [4:0]  rd;
    logic [31:0] d;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("wb_we", wb_we, 1);
      check("wb_reg", wb_reg, e[36:32]);
      check("wb_data", wb_data, e[31:0]);
      m_reg = e[36:32];
      m_data = e[31:0];
      m_known = 1;
    end else begin
      check("wb_we_idle", wb_we, 0);
      if (m_known) begin
        check("wb_reg_hold", wb_reg, m_reg);
        check("wb_data_hold", wb_data, m_data);
      end
    end
    check("busy", busy, m_busy);
    eg1 = r1_valid && (m_wait >= STARVE_LIMIT || !r0_valid);
    eg0 = r0_valid && !eg1;
    check("r0_ready", r0_ready, eg0);
    check("r1_ready", r1_ready, eg1);
    if (rst) begin
      exp_q.delete();
      m_busy = '0;
      m_wait = 0;
      m_reg = '0;
      m_data = '0;
      m_known = 1;
    end else begin
      if (eg0 || eg1) begin
        rd = eg1 ? r1_rd : r0_rd;
        d  = eg1 ? r1_data : r0_data;
        if (rd != 0) begin
          exp_q.push_back({rd, d});
          m_busy[rd] = 1'b0;
        end else begin
          m_known = 0;
        end
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      if (r1_valid && !eg1) m_wait = (m_wait < STARVE_LIMIT) ? m_wait + 1 : m_wait;
      else m_wait = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_valid = 0; r0_rd = '0; r0_data = '0;
    r1_valid = 0; r1_rd = '0; r1_data = '0;
    iss_valid = 0; iss_rd = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    m_busy = '0; m_wait = 0; m_reg = '0; m_data = '0; m_known = 1;
    repeat (2) @(posedge clk);
    #1;
    step(g0, g1);
    rst = 0;

    // single ALU write, then idle
    r0_valid = 1; r0_rd = 5'd5; r0_data = 32'hDEADBEEF;
    step(g0, g1);
    idle_inputs();
    repeat (2) step(g0, g1);

    // both held: r0 wins four cycles, r1 forced on the fifth
    r0_valid = 1; r0_rd = 5'd1; r0_data = $urandom;
    r1_valid = 1; r1_rd = 5'd7; r1_data = 32'h11;
    for (int k = 0; k < 7; k++) begin
      step(g0, g1);
      if (g0) r0_data = $urandom;
      if (g1) r1_valid = 0;
    end
    idle_inputs();
    step(g0, g1);

    // r1 alone
    r1_valid = 1; r1_rd = 5'd9; r1_data = 32'hCAFE0009;
    step(g0, g1);
    idle_inputs();
    repeat (2) step(g0, g1);

    // scoreboard set, clear, and same-cycle set-wins
    iss_valid = 1; iss_rd = 5'd3;
    step(g0, g1);
    idle_inputs();
    step(g0, g1);
    r0_valid = 1; r0_rd = 5'd3; r0_data = 32'h3333;
    step(g0, g1);
    iss_valid = 1; iss_rd = 5'd3;
    step(g0, g1);
    idle_inputs();
    repeat (2) step(g0, g1);

    // writes and issues to x0
    r0_valid = 1; r0_rd = 5'd0; r0_data = 32'hFFFFFFFF;
    iss_valid = 1; iss_rd = 5'd0;
    step(g0, g1);
    idle_inputs();
    repeat (2) step(g0, g1);

    // reset mid-operation with busy=0x88, cnt=2, wb_we=1
    iss_valid = 1; iss_rd = 5'd3;
    step(g0, g1);
    iss_rd = 5'd7;
    step(g0, g1);
    iss_valid = 0;
    r0_valid = 1; r0_rd = 5'd1; r0_data = 32'hA0A0A0A0;
    r1_valid = 1; r1_rd = 5'd2; r1_data = 32'hB1B1B1B1;
    repeat (2) step(g0, g1);
    rst = 1;
    step(g0, g1);
    rst = 0;
    for (int k = 0; k < 8; k++) begin
      step(g0, g1);
      if (g1) r1_valid = 0;
    end
    idle_inputs();
    step(g0, g1);

    // randomized traffic honouring hold-until-accepted
    g0 = 0; g1 = 0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!r0_valid || g0) begin
        r0_valid = ($urandom_range(0, 1) == 1);
        r0_rd = 5'($urandom_range(0, 31));
        r0_data = $urandom;
      end
      if (!r1_valid || g1) begin
        r1_valid = ($urandom_range(0, 3) != 0);
        r1_rd = 5'($urandom_range(0, 31));
        r1_data = $urandom;
      end
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd = 5'($urandom_range(0, 31));
      step(g0, g1);
    end
    idle_inputs();
    rst = 0;
    repeat (2) step(g0, g1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters.
- Requester 0 is the single-cycle ALU path. Requester 1 is the long-latency load/mul-div path.
- Arbitration is fixed-priority with a starvation guard, and the output is registered.
- A 32-entry busy scoreboard tracks destination registers with outstanding writes, so issue logic can stall on RAW hazards.

Parameters:
- STARVE_LIMIT, 4: number of consecutive cycles requester 1 may be denied before it is forced to win.
- CNT_W, 3: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- r0_valid  in  1  ALU writeback request
- r0_rd  in  5  ALU destination register
- r0_data  in  32  ALU result
- r0_ready  out  1  ALU request accepted this cycle
- r1_valid  in  1  long-latency writeback request
- r1_rd  in  5  long-latency destination register
- r1_data  in  32  long-latency result
- r1_ready  out  1  long-latency request accepted this cycle
- iss_valid  in  1  instruction issued that will write iss_rd
- iss_rd  in  5  destination of the issued instruction
- wb_we  out  1  register file writeEnable
- wb_reg  out  5  register file writeReg
- wb_data  out  32  register file writeData
- busy  out  32  scoreboard vector; bit i set means a write to xi is pending

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high. The rst port is sampled on the rising edge of clk.
- Reset values: wb_we=0, wb_reg=0, wb_data=0, busy=0, starvation counter=0.
- Handshake:
  - A transfer occurs when rN_valid && rN_ready.
  - r0_ready and r1_ready are combinational from the valids and the counter, with no dependence on any downstream signal.
  - At most one ready is high per cycle. A ready is never high while its own valid is low.
- Grant rules, evaluated per cycle:
  - force = r1_valid && (cnt == STARVE_LIMIT).
  - r1 granted if force, or if r1_valid && !r0_valid.
  - Otherwise r0 is granted if r0_valid.
- Starvation counter:
  - Increments when r1_valid && !r1_ready.
  - Clears when r1 is granted or when r1_valid is low.
  - Saturates at STARVE_LIMIT.
- Latency:
  - An accepted request in cycle N appears on wb_we/wb_reg/wb_data in cycle N+1, registered.
  - In N+1 the output carries wb_we=1, wb_reg=rd and wb_data=data.
  - When nothing is accepted, wb_we=0 the following cycle. wb_reg and wb_data hold their previous values.
- Requests to x0:
  - An accepted request with rd=0 completes the handshake normally.
  - It produces wb_we=0 in the next cycle.
- Scoreboard:
  - iss_valid && iss_rd!=0 sets busy[iss_rd] at the clock edge.
  - An accepted writeback to rd!=0 clears busy[rd] at the same edge the request is accepted, i.e. cycle N, not N+1.
  - Set and clear of the same rd in the same cycle: set wins, because a newer writer is outstanding.
  - busy[0] is constant 0.
  - iss_rd to an already-busy register leaves the bit set. The block tracks no write counts; issue logic must not issue WAW to a busy register.
- Reset mid-operation:
  - Any request accepted in the reset cycle is discarded.
  - wb_we=0 in the next cycle, and all busy bits clear.
  - Valids held high through reset are re-arbitrated from cnt=0 afterwards.
- No buffering: a denied requester must hold valid, rd and data stable until it is accepted.

Test Plan:
- Reset, then r0_valid=1 with rd=5 and data=0xDEADBEEF for one cycle -> r0_ready=1. Next cycle wb_we=1, wb_reg=5, wb_data=0xDEADBEEF. The cycle after, wb_we=0.
- r0_valid and r1_valid held high continuously, STARVE_LIMIT=4 -> r0 wins cycles 0-3 and r1 wins cycle 4. r1 (rd=7, data=0x11) appears on wb in cycle 5 and the counter returns to 0.
- r1_valid alone with rd=9 -> r1_ready=1 in the same cycle. Next cycle wb_we=1, wb_reg=9.
- iss_valid with iss_rd=3, then two cycles later r0 accepted with rd=3 -> busy[3]=1 from the edge after issue, cleared at the acceptance edge. Same-cycle iss_rd=3 plus r0 rd=3 accept leaves busy[3]=1.
- r0 request with rd=0 and data=0xFFFFFFFF -> r0_ready=1, next cycle wb_we=0. iss_rd=0 leaves busy=0.
- With busy=0x0000_0088, wb_we=1 and cnt=2, assert rst for one cycle -> next cycle wb_we=0, busy=0, cnt=0. A held r1 request is granted normally afterwards.
